muldiv_seq: RTL and testbench

//   Iterative RV32M multiply/divide unit with its own sequencing FSM. Sits

---
 rtl/muldiv_seq_if.sv | 25 ++
 rtl/muldiv_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// The pipeline side uses the master modport. The muldiv_seq unit uses the slave modport.
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic            stall;

   modport master (
      output start, funct3, rs1_data, rs2_data, flush,
      input  busy, done, result, stall
   );

   modport slave (
      input  start, funct3, rs1_data, rs2_data, flush,
      output busy, done, result, stall
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit.
// It accepts one M-extension op in IDLE and runs 32 radix-2 steps in CALC.
// The steps are shift-add for multiply and restoring division for divide.
// The sign fix-up happens when CALC hands over to DONE.
// DONE presents the result with a one-cycle done pulse.
// Divide-by-zero and signed overflow can bypass the loop.
module muldiv_seq #(
   parameter int XLEN      = 32,
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   muldiv_seq_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [5:0]      LAST_IT  = 6'(XLEN - 1);

   // Two's-complement negate on a single word, applied only when en is set.
   function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic en);
      return en ? ({XLEN{1'b0}} - v) : v;
   endfunction

   // Two's-complement negate on a double word, applied only when en is set.
   function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v, input logic en);
      return en ? ({(2*XLEN){1'b0}} - v) : v;
   endfunction

   state_t          state, state_nxt;
   logic [2:0]      op;
   logic            sign_a, sign_b;
   logic [XLEN-1:0] opnd;
   logic [XLEN-1:0] acc_hi;
   logic [XLEN-1:0] acc_lo;
   logic [5:0]      count;
   logic [XLEN-1:0] result_q;
   logic            busy_q, done_q;

   logic            accept, take_early, iterate, finish, stall_c;

   logic signed [XLEN-1:0] a_s, b_s;
   logic            in_is_div, in_is_rem, in_sa_op, in_sb_op;
   logic            in_sign_a, in_sign_b;
   logic [XLEN-1:0] in_a_mag, in_b_mag;
   logic            in_div_zero, in_ovf, early_hit;
   logic [XLEN-1:0] early_val;

   logic            is_div;
   logic [XLEN-1:0] add_val;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift, div_diff;
   logic [XLEN-1:0] hi_nxt, lo_nxt;

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

   // Decode the incoming request, take operand magnitudes and spot the bypass cases.
   always_comb begin
      a_s         = signed'(bus.rs1_data);
      b_s         = signed'(bus.rs2_data);
      in_is_div   = bus.funct3[2];
      in_is_rem   = bus.funct3[2] & bus.funct3[1];
      // MULH, MULHSU, DIV and REM treat rs1 as signed.
      in_sa_op    = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                    (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
      // MULH, DIV and REM treat rs2 as signed.
      in_sb_op    = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) ||
                    (bus.funct3 == 3'd6);
      in_sign_a   = in_sa_op & (a_s < 0);
      in_sign_b   = in_sb_op & (b_s < 0);
      // The magnitude of INT_MIN is INT_MIN read as unsigned, which is exact.
      in_a_mag    = neg_w(bus.rs1_data, in_sign_a);
      in_b_mag    = neg_w(bus.rs2_data, in_sign_b);
      in_div_zero = (bus.rs2_data == {XLEN{1'b0}});
      in_ovf      = in_sb_op & in_is_div &
                    (bus.rs1_data == INT_MIN) && (bus.rs2_data == ALL_ONES);
      early_hit   = EARLY_OUT & in_is_div & (in_div_zero | in_ovf);
      early_val   = ALL_ONES;
      if (in_div_zero) begin
         early_val = in_is_rem ? bus.rs1_data : ALL_ONES;
      end else if (in_ovf) begin
         early_val = in_is_rem ? {XLEN{1'b0}} : INT_MIN;
      end
   end

   // Sequencing: next state plus the load, iterate and finish strobes.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      take_early = 1'b0;
      iterate    = 1'b0;
      finish     = 1'b0;
      stall_c    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.start && !bus.flush) begin
               stall_c = 1'b1;
               accept  = 1'b1;
               if (early_hit) begin
                  take_early = 1'b1;
                  state_nxt  = S_DONE;
               end else begin
                  state_nxt  = S_CALC;
               end
            end
         end
         S_CALC: begin
            stall_c = 1'b1;
            if (bus.flush) begin
               state_nxt = S_IDLE;
            end else begin
               iterate = 1'b1;
               if (count == LAST_IT) begin
                  finish    = 1'b1;
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // One radix-2 step.
   // Multiply uses shift-add from the LSB of the multiplier.
   // Divide uses restoring division on a 33-bit partial remainder.
   always_comb begin
      is_div    = op[2];
      add_val   = acc_lo[0] ? opnd : {XLEN{1'b0}};
      mul_sum   = {1'b0, acc_hi} + {1'b0, add_val};
      div_shift = {acc_hi, acc_lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd};
      if (is_div) begin
         // Bit 32 of the difference clear means the divisor fits, so keep the subtraction.
         if (!div_diff[XLEN]) begin
            hi_nxt = div_diff[XLEN-1:0];
            lo_nxt = {acc_lo[XLEN-2:0], 1'b1};
         end else begin
            hi_nxt = div_shift[XLEN-1:0];
            lo_nxt = {acc_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_nxt = mul_sum[XLEN:1];
         lo_nxt = {mul_sum[0], acc_lo[XLEN-1:1]};
      end
   end

   // Sign fix-up and result selection, computed from the final step's values.
   always_comb begin
      prod_fix = neg_dw({hi_nxt, lo_nxt}, sign_a ^ sign_b);
      // A zero divisor already yields all-ones, which is -1. It must not be negated.
      quo_fix  = neg_w(lo_nxt, (sign_a ^ sign_b) & (opnd != {XLEN{1'b0}}));
      rem_fix  = neg_w(hi_nxt, sign_a);
      unique case (op)
         3'd0:          calc_res = prod_fix[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:          calc_res = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:    calc_res = quo_fix;
         default:       calc_res = rem_fix;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Operand capture, the iteration registers, the step counter and the result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op       <= 3'd0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         opnd     <= {XLEN{1'b0}};
         acc_hi   <= {XLEN{1'b0}};
         acc_lo   <= {XLEN{1'b0}};
         count    <= 6'd0;
         result_q <= {XLEN{1'b0}};
      end else begin
         if (accept) begin
            op     <= bus.funct3;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            count  <= 6'd0;
            acc_hi <= {XLEN{1'b0}};
            if (in_is_div) begin
               acc_lo <= in_a_mag;
               opnd   <= in_b_mag;
            end else begin
               acc_lo <= in_b_mag;
               opnd   <= in_a_mag;
            end
            if (take_early) result_q <= early_val;
         end
         if (iterate) begin
            acc_hi <= hi_nxt;
            acc_lo <= lo_nxt;
            count  <= count + 6'd1;
         end
         if (finish) result_q <= calc_res;
      end
   end

   // Registered status flags, decoded from the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= (state_nxt != S_IDLE);
         done_q <= (state_nxt == S_DONE);
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.stall  = stall_c;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with hand-computed expected results.
module tb_muldiv_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   muldiv_seq_if #(.XLEN(32)) bus();

   muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op in IDLE. Scramble the inputs after acceptance.
   // Then wait a bounded time for done and check latency, result and return to IDLE.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int   n;
      logic calc_ok;
      bus.funct3   = f3;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.start    = 1'b1;
      #1;
      check_eq({tag, "_stall_req"}, 32'(bus.stall), 32'd1);
      tick();
      bus.start    = 1'b0;
      bus.funct3   = ~f3;
      bus.rs1_data = ~a ^ 32'h5A5A_0000;
      bus.rs2_data = b + 32'd3;
      n       = 0;
      calc_ok = 1'b1;
      while (!bus.done && n < 40) begin
         if (!bus.stall || !bus.busy) calc_ok = 1'b0;
         tick();
         n++;
      end
      check_eq({tag, "_lat"}, 32'(n), 32'(lat));
      check_eq({tag, "_result"}, bus.result, exp);
      check_eq({tag, "_calc_stall_busy"}, 32'(calc_ok), 32'd1);
      check_eq({tag, "_done_stall_busy"}, {30'd0, bus.stall, bus.busy}, 32'd1);
      tick();
      check_eq({tag, "_back_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          n;
      int          dones;
      int          first;
      logic        seen;
      logic [31:0] prev;

      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.flush    = 1'b0;
      bus.funct3   = 3'd0;
      bus.rs1_data = 32'd0;
      bus.rs2_data = 32'd0;
      tick();
      tick();
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_result", bus.result, 32'd0);
      check_eq("rst_stall_idle", 32'(bus.stall), 32'd0);
      bus.start = 1'b1;
      #1;
      check_eq("rst_stall_follows_start", 32'(bus.stall), 32'd1);
      bus.start = 1'b0;
      rst_n     = 1'b1;
      tick();

      // Multiply family.
      run_op("mul_7_m3",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
      run_op("mulh_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
      run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
      run_op("mulhsu_max",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);

      // Divide family.
      run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32);
      run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32);
      run_op("div_7_m2",    3'd4, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
      run_op("rem_7_m2",    3'd6, 32'd7,        32'hFFFF_FFFE, 32'd1,        32);
      run_op("divu_100_7",  3'd5, 32'd100,      32'd7,        32'd14,       32);
      run_op("remu_100_7",  3'd7, 32'd100,      32'd7,        32'd2,        32);

      // Early-out special cases: done on the cycle right after acceptance.
      run_op("div_5_0",     3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 0);
      run_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        0);
      run_op("remu_5_0",    3'd7, 32'd5,        32'd0,        32'd5,        0);

      // Flush together with start in IDLE: flush wins and nothing is latched.
      bus.funct3   = 3'd5;
      bus.rs1_data = 32'd100;
      bus.rs2_data = 32'd7;
      bus.start    = 1'b1;
      bus.flush    = 1'b1;
      #1;
      check_eq("flush_start_stall", 32'(bus.stall), 32'd0);
      tick();
      bus.start = 1'b0;
      bus.flush = 1'b0;
      check_eq("flush_start_busy", 32'(bus.busy), 32'd0);

      // Flush in CALC: abort without a done, and leave the result unchanged.
      prev         = bus.result;
      bus.funct3   = 3'd5;
      bus.rs1_data = 32'd100;
      bus.rs2_data = 32'd7;
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      seen      = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (bus.done) seen = 1'b1;
         tick();
      end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check_eq("flush_no_done_calc", 32'(seen), 32'd0);
      check_eq("flush_busy", 32'(bus.busy), 32'd0);
      check_eq("flush_done", 32'(bus.done), 32'd0);
      check_eq("flush_result_kept", bus.result, prev);
      run_op("divu_after_flush", 3'd5, 32'd100, 32'd7, 32'd14, 32);

      // Start held high during CALC is ignored, so only one done pulse appears.
      bus.funct3   = 3'd3;
      bus.rs1_data = 32'hFFFF_FFFF;
      bus.rs2_data = 32'hFFFF_FFFF;
      bus.start    = 1'b1;
      tick();
      dones = 0;
      first = -1;
      for (int i = 1; i <= 45; i++) begin
         tick();
         if (i == 4) bus.start = 1'b0;
         if (bus.done) begin
            dones++;
            if (first < 0) first = i;
         end
      end
      check_eq("calc_start_ignored_dones", 32'(dones), 32'd1);
      check_eq("calc_start_ignored_lat", 32'(first), 32'd32);
      check_eq("calc_start_ignored_result", bus.result, 32'hFFFF_FFFE);

      // Asynchronous reset in the middle of CALC.
      bus.funct3   = 3'd0;
      bus.rs1_data = 32'd7;
      bus.rs2_data = 32'hFFFF_FFFD;
      bus.start    = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      repeat (4) begin
         tick();
         n++;
      end
      rst_n = 1'b0;
      #1;
      check_eq("midrst_busy", 32'(bus.busy), 32'd0);
      check_eq("midrst_done", 32'(bus.done), 32'd0);
      check_eq("midrst_result", bus.result, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      run_op("mul_after_rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
